// File: rtl/interrupt_unit_if.sv
// rtl/interrupt_unit_if.sv - pin bundle between the interrupt unit and the pipeline/stack/memory ports
interface interrupt_unit_if #(
  parameter int PC_W   = 32,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 20
);
  logic              irq_in;
  logic [PC_W-1:0]   fetch_pc;
  logic              pipe_busy;
  logic              push_ready;
  logic              vec_valid;
  logic [DATA_W-1:0] vec_data;
  logic              rti_done;
  logic              stall_fetch;
  logic              inject_nop;
  logic              push_valid;
  logic [DATA_W-1:0] push_data;
  logic              vec_rd;
  logic [ADDR_W-1:0] vec_addr;
  logic              pc_load;
  logic [PC_W-1:0]   pc_load_val;
  logic              int_active;
  logic [7:0]        drop_cnt;

  modport master (
    output irq_in, fetch_pc, pipe_busy, push_ready, vec_valid, vec_data, rti_done,
    input  stall_fetch, inject_nop, push_valid, push_data, vec_rd, vec_addr,
           pc_load, pc_load_val, int_active, drop_cnt
  );

  modport slave (
    input  irq_in, fetch_pc, pipe_busy, push_ready, vec_valid, vec_data, rti_done,
    output stall_fetch, inject_nop, push_valid, push_data, vec_rd, vec_addr,
           pc_load, pc_load_val, int_active, drop_cnt
  );
endinterface

// File: rtl/interrupt_unit.sv
// rtl/interrupt_unit.sv - external interrupt synchroniser, pending latch and entry sequencer
module interrupt_unit #(
  parameter int                PC_W         = 32,
  parameter int                DATA_W       = 16,
  parameter int                ADDR_W       = 20,
  parameter logic [ADDR_W-1:0] VEC_ADDR     = 'h2,
  parameter int                DRAIN_CYCLES = 4
) (
  input logic              clk,
  input logic              reset,
  interrupt_unit_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, DRAIN, PUSH_HI, PUSH_LO, VEC, LOAD} state_t;

  state_t            state;
  logic [7:0]        cnt;
  logic [PC_W-1:0]   savedPc;
  logic [DATA_W-1:0] vector;
  logic [DATA_W-1:0] pushData;
  logic              stallFetch, injectNop, pushValid, vecRd, pcLoad, intActive;
  logic              s1, s2, s3, pending;
  logic [7:0]        dropCnt;
  logic              edgeDet, goCond;

  assign edgeDet = s2 & ~s3;
  assign goCond  = (state == IDLE) & pending & ~intActive & ~bus.pipe_busy;

  // An edge arriving while the pending request is being consumed becomes the new pending one
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      s3      <= 1'b0;
      pending <= 1'b0;
      dropCnt <= 8'd0;
    end else begin
      s1 <= bus.irq_in;
      s2 <= s1;
      s3 <= s2;
      if (edgeDet)
        pending <= 1'b1;
      else if (goCond)
        pending <= 1'b0;
      if (edgeDet && pending && !goCond && dropCnt != 8'hFF)
        dropCnt <= dropCnt + 8'd1;
    end
  end

  // Output flops are loaded with the decode of the state being entered
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      savedPc    <= '0;
      vector     <= '0;
      pushData   <= '0;
      stallFetch <= 1'b0;
      injectNop  <= 1'b0;
      pushValid  <= 1'b0;
      vecRd      <= 1'b0;
      pcLoad     <= 1'b0;
      intActive  <= 1'b0;
    end else begin
      if (bus.rti_done && intActive)
        intActive <= 1'b0;
      case (state)
        IDLE: begin
          if (goCond) begin
            state      <= DRAIN;
            savedPc    <= bus.fetch_pc;
            cnt        <= 8'(DRAIN_CYCLES - 1);
            stallFetch <= 1'b1;
            injectNop  <= 1'b1;
          end
        end
        DRAIN: begin
          if (cnt == 8'd0) begin
            state     <= PUSH_HI;
            injectNop <= 1'b0;
            pushValid <= 1'b1;
            pushData  <= savedPc[PC_W-1 -: DATA_W];
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        PUSH_HI: begin
          if (bus.push_ready) begin
            state    <= PUSH_LO;
            pushData <= savedPc[DATA_W-1:0];
          end
        end
        PUSH_LO: begin
          if (bus.push_ready) begin
            state     <= VEC;
            pushValid <= 1'b0;
            pushData  <= '0;
            vecRd     <= 1'b1;
          end
        end
        VEC: begin
          if (bus.vec_valid) begin
            state  <= LOAD;
            vector <= bus.vec_data;
            vecRd  <= 1'b0;
            pcLoad <= 1'b1;
          end
        end
        LOAD: begin
          state      <= IDLE;
          pcLoad     <= 1'b0;
          stallFetch <= 1'b0;
          intActive  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.stall_fetch = stallFetch;
  assign bus.inject_nop  = injectNop;
  assign bus.push_valid  = pushValid;
  assign bus.push_data   = pushData;
  assign bus.vec_rd      = vecRd;
  assign bus.vec_addr    = vecRd ? VEC_ADDR : '0;
  assign bus.pc_load     = pcLoad;
  assign bus.pc_load_val = {{(PC_W-DATA_W){1'b0}}, vector};
  assign bus.int_active  = intActive;
  assign bus.drop_cnt    = dropCnt;

endmodule
